// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch stage: exception codes, the issued-word record
// and a small address helper.
package fetch_redirect_unit_pkg;

    localparam logic [7:0] TRAP_NONE        = 8'h00;
    localparam logic [7:0] TRAP_STALL       = 8'h0F;
    localparam logic [7:0] TRAP_FETCH_ALIGN = 8'h10;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] next_pc;
        logic        br_trigger;
    } fetch_word_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word that arrives while decode is stalled.
module fetch_skid_buffer
    import fetch_redirect_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  fetch_word_t din,
    output fetch_word_t dout,
    output logic        full,
    output logic        empty
);

    fetch_word_t data_r;
    logic        full_r;

    // Capture on push, release on pop; push only happens while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
            full_r <= 1'b0;
        end else if (push) begin
            data_r <= din;
            full_r <= 1'b1;
        end else if (pop) begin
            data_r <= data_r;
            full_r <= 1'b0;
        end else begin
            data_r <= data_r;
            full_r <= full_r;
        end
    end

    assign dout  = data_r;
    assign full  = full_r;
    assign empty = ~full_r;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch and PC sequencing with delay-slot redirects, in-flight discard,
// misaligned-target faulting and a one-word skid buffer under decode stall.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_enable,
    input  logic [31:0] br_target,
    input  logic        stall_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] next_pc,
    output logic        br_trigger,
    output logic [7:0]  exception
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [31:0] pc_r, pc_nx_s;
    logic        redir_flag_r, redir_nx_s;
    logic        fault_pending_r, fault_pending_nx_s;
    logic [31:0] fault_npc_r, fault_npc_nx_s;
    logic        imem_req_r, req_nx_s;
    logic [31:0] imem_addr_r, addr_nx_s;
    logic [31:0] inst_r, next_pc_r;
    logic        inst_valid_r, br_trigger_r;
    logic [7:0]  exception_r;

    logic        hs_s, br_aligned_s, br_misaligned_s, deliver_s, fault_issue_s;
    logic        skid_push_s, skid_pop_s, skid_full_s, skid_empty_s, skid_full_nx_s;
    fetch_word_t fetch_word_s, skid_word_s;

    assign hs_s            = imem_req_r & imem_ready;
    assign br_aligned_s    = br_enable & is_word_aligned(br_target);
    assign br_misaligned_s = br_enable & ~is_word_aligned(br_target);
    // Words returning while DISCARD are dropped; only FETCH delivers them
    assign deliver_s       = hs_s & (state_r == ST_FETCH);
    assign fault_issue_s   = (state_r == ST_FAULT) & fault_pending_r & ~stall_in & skid_empty_s;
    assign skid_push_s     = deliver_s & stall_in;
    assign skid_pop_s      = ~skid_empty_s & ~stall_in;
    assign skid_full_nx_s  = skid_push_s | (skid_full_s & stall_in);
    assign fetch_word_s    = '{inst: imem_rdata, next_pc: imem_addr_r + 32'd4, br_trigger: redir_flag_r};

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (skid_push_s),
        .pop   (skid_pop_s),
        .din   (fetch_word_s),
        .dout  (skid_word_s),
        .full  (skid_full_s),
        .empty (skid_empty_s)
    );

    // Next-state, PC and redirect bookkeeping
    always_comb begin
        state_nx_s         = state_r;
        pc_nx_s            = pc_r;
        redir_nx_s         = redir_flag_r;
        fault_pending_nx_s = fault_pending_r;
        fault_npc_nx_s     = fault_npc_r;
        case (state_r)
            ST_FETCH: begin
                if (br_misaligned_s) begin
                    state_nx_s         = ST_FAULT;
                    fault_pending_nx_s = 1'b1;
                    fault_npc_nx_s     = br_target + 32'd4;
                    redir_nx_s         = 1'b0;
                end else if (br_aligned_s) begin
                    pc_nx_s    = br_target;
                    redir_nx_s = 1'b1;
                    if (imem_req_r & ~imem_ready) begin
                        state_nx_s = ST_DISCARD;
                    end else begin
                        state_nx_s = ST_FETCH;
                    end
                end else if (hs_s) begin
                    pc_nx_s    = pc_r + 32'd4;
                    redir_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (br_misaligned_s) begin
                    state_nx_s         = ST_FAULT;
                    fault_pending_nx_s = 1'b1;
                    fault_npc_nx_s     = br_target + 32'd4;
                    redir_nx_s         = 1'b0;
                end else begin
                    if (br_aligned_s) begin
                        pc_nx_s = br_target;
                    end else begin
                        pc_nx_s = pc_r;
                    end
                    if (hs_s) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_DISCARD;
                    end
                end
            end
            ST_FAULT: begin
                if (br_aligned_s) begin
                    state_nx_s         = ST_FETCH;
                    pc_nx_s            = br_target;
                    redir_nx_s         = 1'b1;
                    fault_pending_nx_s = 1'b0;
                end else if (br_misaligned_s) begin
                    fault_pending_nx_s = 1'b1;
                    fault_npc_nx_s     = br_target + 32'd4;
                end else if (fault_issue_s) begin
                    fault_pending_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_FAULT;
                end
            end
            default: begin
                state_nx_s = ST_FETCH;
            end
        endcase
    end

    // Request generation: no new request while the skid entry is occupied
    always_comb begin
        req_nx_s = 1'b0;
        case (state_nx_s)
            ST_FETCH:   req_nx_s = ~skid_full_nx_s;
            ST_DISCARD: req_nx_s = 1'b1;
            default:    req_nx_s = 1'b0;
        endcase
        if (state_nx_s == ST_DISCARD) begin
            addr_nx_s = imem_addr_r;
        end else begin
            addr_nx_s = pc_nx_s;
        end
    end

    // FSM state, fetch request and issue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_FETCH;
            pc_r            <= RESET_PC;
            redir_flag_r    <= 1'b0;
            fault_pending_r <= 1'b0;
            fault_npc_r     <= 32'h0000_0000;
            imem_req_r      <= 1'b0;
            imem_addr_r     <= 32'h0000_0000;
            inst_r          <= 32'h0000_0000;
            next_pc_r       <= 32'h0000_0000;
            inst_valid_r    <= 1'b0;
            br_trigger_r    <= 1'b0;
            exception_r     <= TRAP_STALL;
        end else begin
            state_r         <= state_nx_s;
            pc_r            <= pc_nx_s;
            redir_flag_r    <= redir_nx_s;
            fault_pending_r <= fault_pending_nx_s;
            fault_npc_r     <= fault_npc_nx_s;
            imem_req_r      <= req_nx_s;
            imem_addr_r     <= addr_nx_s;
            if (stall_in) begin
                inst_r       <= inst_r;
                next_pc_r    <= next_pc_r;
                inst_valid_r <= inst_valid_r;
                br_trigger_r <= br_trigger_r;
                exception_r  <= exception_r;
            end else if (~skid_empty_s) begin
                inst_r       <= skid_word_s.inst;
                next_pc_r    <= skid_word_s.next_pc;
                inst_valid_r <= 1'b1;
                br_trigger_r <= skid_word_s.br_trigger;
                exception_r  <= TRAP_NONE;
            end else if (deliver_s) begin
                inst_r       <= fetch_word_s.inst;
                next_pc_r    <= fetch_word_s.next_pc;
                inst_valid_r <= 1'b1;
                br_trigger_r <= fetch_word_s.br_trigger;
                exception_r  <= TRAP_NONE;
            end else if (fault_issue_s) begin
                inst_r       <= 32'h0000_0000;
                next_pc_r    <= fault_npc_r;
                inst_valid_r <= 1'b1;
                br_trigger_r <= 1'b1;
                exception_r  <= TRAP_FETCH_ALIGN;
            end else begin
                inst_r       <= inst_r;
                next_pc_r    <= next_pc_r;
                inst_valid_r <= 1'b0;
                br_trigger_r <= 1'b0;
                exception_r  <= TRAP_STALL;
            end
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = imem_addr_r;
    assign inst       = inst_r;
    assign next_pc    = next_pc_r;
    assign inst_valid = inst_valid_r;
    assign br_trigger = br_trigger_r;
    assign exception  = exception_r;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios plus a randomized run checked
// against a stream-level model of the issued instruction sequence.
module tb_fetch_redirect_unit;
    import fetch_redirect_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, br_enable, stall_in, imem_ready;
    logic [31:0] br_target, imem_rdata;
    logic        imem_req, inst_valid, br_trigger;
    logic [31:0] imem_addr, inst, next_pc;
    logic [7:0]  exception;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    fetch_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .br_enable(br_enable), .br_target(br_target),
        .stall_in(stall_in), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst(inst),
        .inst_valid(inst_valid), .next_pc(next_pc), .br_trigger(br_trigger),
        .exception(exception)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1357_2468;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (!rst && imem_req && imem_ready) hs_cnt = hs_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; br_enable = 1'b0; br_target = 32'h0; stall_in = 1'b0; imem_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic wait_issue(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_issue: no issue within 20 cycles, required an issue"); end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (imem_req !== 1'b0)     begin errors++; $display("FAIL rst_req: got %0b want 0", imem_req); end
        if (imem_addr !== 32'h0)   begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        if (inst_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %0b want 0", inst_valid); end
        if (next_pc !== 32'h0)     begin errors++; $display("FAIL rst_npc: got %h want 0", next_pc); end
        if (br_trigger !== 1'b0)   begin errors++; $display("FAIL rst_trig: got %0b want 0", br_trigger); end
        if (exception !== TRAP_STALL) begin errors++; $display("FAIL rst_exc: got %h want %h", exception, TRAP_STALL); end
        step();
        checks += 2;
        if (imem_req !== 1'b1)     begin errors++; $display("FAIL req_rise: got %0b want 1", imem_req); end
        if (imem_addr !== 32'h0)   begin errors++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        step();
        for (int i = 1; i <= 3; i++) begin
            logic [31:0] want_npc;
            want_npc = 32'(4 * i);
            step();
            checks += 4;
            if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %0b want 1", i, inst_valid); end
            if (next_pc !== want_npc) begin errors++; $display("FAIL seq_npc[%0d]: got %h want %h", i, next_pc, want_npc); end
            if (inst !== mem_word(want_npc - 32'd4)) begin errors++; $display("FAIL seq_inst[%0d]: got %h want %h", i, inst, mem_word(want_npc - 32'd4)); end
            if (exception !== TRAP_NONE) begin errors++; $display("FAIL seq_exc[%0d]: got %h want 0", i, exception); end
        end
    endtask

    task automatic test_redirect_ready();
        do_reset();
        repeat (4) step();
        br_enable = 1'b1; br_target = 32'h100;
        step();
        br_enable = 1'b0;
        checks += 2;
        if (next_pc !== 32'h10 || inst !== mem_word(32'hC)) begin errors++; $display("FAIL delay_slot: got npc %h inst %h want npc 10 inst %h", next_pc, inst, mem_word(32'hC)); end
        if (br_trigger !== 1'b0) begin errors++; $display("FAIL delay_slot_trig: got %0b want 0", br_trigger); end
        step();
        checks += 2;
        if (next_pc !== 32'h104 || inst !== mem_word(32'h100)) begin errors++; $display("FAIL redir_target: got npc %h inst %h want npc 104 inst %h", next_pc, inst, mem_word(32'h100)); end
        if (br_trigger !== 1'b1) begin errors++; $display("FAIL redir_trig: got %0b want 1", br_trigger); end
        step();
        checks++;
        if (br_trigger !== 1'b0 || next_pc !== 32'h108) begin errors++; $display("FAIL after_trig: got trig %0b npc %h want 0 108", br_trigger, next_pc); end
    endtask

    task automatic test_discard();
        logic ok;
        do_reset();
        step(); step();
        imem_ready = 1'b0;
        step();
        br_enable = 1'b1; br_target = 32'h40;
        step();
        br_enable = 1'b0;
        checks++;
        if (imem_addr !== 32'h4) begin errors++; $display("FAIL discard_hold: got addr %h want 4", imem_addr); end
        step();
        imem_ready = 1'b1;
        wait_issue(ok);
        checks++;
        if (ok && (next_pc !== 32'h44 || br_trigger !== 1'b1 || inst !== mem_word(32'h40))) begin
            errors++; $display("FAIL discard_target: got npc %h trig %0b want npc 44 trig 1", next_pc, br_trigger);
        end
    endtask

    task automatic test_misaligned();
        logic ok;
        do_reset();
        step(); step();
        br_enable = 1'b1; br_target = 32'h102;
        step();
        br_enable = 1'b0;
        checks++;
        if (next_pc !== 32'h8 || br_trigger !== 1'b0) begin errors++; $display("FAIL mis_delay: got npc %h trig %0b want 8 0", next_pc, br_trigger); end
        step();
        checks += 3;
        if (exception !== TRAP_FETCH_ALIGN) begin errors++; $display("FAIL mis_exc: got %h want %h", exception, TRAP_FETCH_ALIGN); end
        if (next_pc !== 32'h106 || inst !== 32'h0) begin errors++; $display("FAIL mis_slot: got npc %h inst %h want 106 0", next_pc, inst); end
        if (inst_valid !== 1'b1 || br_trigger !== 1'b1) begin errors++; $display("FAIL mis_flags: got valid %0b trig %0b want 1 1", inst_valid, br_trigger); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (exception !== TRAP_STALL || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                errors++; $display("FAIL fault_idle[%0d]: got exc %h req %0b valid %0b want %h 0 0", i, exception, imem_req, inst_valid, TRAP_STALL);
            end
        end
        br_enable = 1'b1; br_target = 32'h200;
        step();
        br_enable = 1'b0;
        wait_issue(ok);
        checks++;
        if (ok && (next_pc !== 32'h204 || br_trigger !== 1'b1 || exception !== TRAP_NONE)) begin
            errors++; $display("FAIL fault_resume: got npc %h trig %0b exc %h want 204 1 0", next_pc, br_trigger, exception);
        end
    endtask

    task automatic test_stall();
        logic ok;
        logic [31:0] f_inst, f_npc;
        int hs0;
        do_reset();
        step(); step(); step();
        f_inst = inst; f_npc = next_pc;
        hs0 = hs_cnt;
        stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (inst !== f_inst || next_pc !== f_npc || inst_valid !== 1'b1 || exception !== TRAP_NONE) begin
                errors++; $display("FAIL stall_freeze[%0d]: got npc %h valid %0b want npc %h valid 1", i, next_pc, inst_valid, f_npc);
            end
        end
        stall_in = 1'b0;
        checks++;
        if (hs_cnt - hs0 > 2) begin errors++; $display("FAIL stall_fetches: got %0d want at most 2", hs_cnt - hs0); end
        for (int k = 1; k <= 3; k++) begin
            wait_issue(ok);
            checks++;
            if (ok && (next_pc !== f_npc + 32'(4 * k) || inst !== mem_word(f_npc + 32'(4 * k) - 32'd4))) begin
                errors++; $display("FAIL stall_order[%0d]: got npc %h want %h", k, next_pc, f_npc + 32'(4 * k));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(); step();
        imem_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b1;
        checks += 2;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got req %0b valid %0b want 0 0", imem_req, inst_valid); end
        if (exception !== TRAP_STALL) begin errors++; $display("FAIL mid_rst_exc: got %h want %h", exception, TRAP_STALL); end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_refetch: got req %0b addr %h want 1 0", imem_req, imem_addr); end
    endtask

    // Stream model: every issue is the memory word at next_pc-4; issues follow in
    // address order except that a redirect allows at most one delay-slot issue and
    // then the target with br_trigger set.
    task automatic test_random();
        logic        pending, stalled;
        logic [31:0] tgt, prev_npc, p_inst, p_npc;
        logic        p_valid, p_trig;
        logic [7:0]  p_exc;
        int          delay;
        do_reset();
        pending = 1'b0; tgt = 32'h0; prev_npc = 32'h0; delay = 0;
        for (int c = 0; c < 3000; c++) begin
            br_enable = 1'b0;
            if (c < 2970) begin
                imem_ready = ($urandom_range(0, 3) != 0);
                stall_in   = ($urandom_range(0, 4) == 0);
                if (!pending && $urandom_range(0, 15) == 0) begin
                    br_enable = 1'b1;
                    br_target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                    tgt = br_target; pending = 1'b1; delay = 0;
                end
            end else begin
                imem_ready = 1'b1; stall_in = 1'b0;
            end
            stalled = stall_in;
            p_inst = inst; p_npc = next_pc; p_valid = inst_valid; p_trig = br_trigger; p_exc = exception;
            step();
            if (stalled) begin
                checks++;
                if (inst !== p_inst || next_pc !== p_npc || inst_valid !== p_valid || br_trigger !== p_trig || exception !== p_exc) begin
                    errors++; $display("FAIL rnd_hold c=%0d: got npc %h valid %0b want npc %h valid %0b", c, next_pc, inst_valid, p_npc, p_valid);
                end
            end else if (inst_valid) begin
                checks += 2;
                if (inst !== mem_word(next_pc - 32'd4)) begin errors++; $display("FAIL rnd_inst c=%0d: got %h want %h", c, inst, mem_word(next_pc - 32'd4)); end
                if (exception !== TRAP_NONE) begin errors++; $display("FAIL rnd_exc c=%0d: got %h want 0", c, exception); end
                checks++;
                if (br_trigger) begin
                    if (!pending || next_pc !== tgt + 32'd4) begin errors++; $display("FAIL rnd_trig c=%0d: got npc %h pending %0b want npc %h", c, next_pc, pending, tgt + 32'd4); end
                    pending = 1'b0;
                end else begin
                    if (next_pc !== prev_npc + 32'd4) begin errors++; $display("FAIL rnd_seq c=%0d: got npc %h want %h", c, next_pc, prev_npc + 32'd4); end
                    if (pending) begin
                        delay++;
                        checks++;
                        if (delay > 1) begin errors++; $display("FAIL rnd_delay c=%0d: got %0d delay issues want at most 1", c, delay); end
                    end
                end
                prev_npc = next_pc;
            end else begin
                checks++;
                if (exception !== TRAP_STALL) begin errors++; $display("FAIL rnd_idle_exc c=%0d: got %h want %h", c, exception, TRAP_STALL); end
            end
        end
        checks++;
        if (pending) begin errors++; $display("FAIL rnd_pending: redirect to %h never issued, required a trigger issue", tgt); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_ready();
        test_discard();
        test_misaligned();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
